// File: rtl/shift_pipe_stage_pkg.sv
// shift_pipe_stage_pkg: shared widths, ALU shift opcodes and stage record types
package shift_pipe_stage_pkg;
  localparam int DATA_W = 32;
  localparam int OPR_W = 6;
  localparam logic [OPR_W-1:0] OPR_SHIFT_R = 6'h04;
  localparam logic [OPR_W-1:0] OPR_SHIFT_L = 6'h05;
  typedef struct packed {
    logic              dir;
    logic              sat;
    logic [4:0]        amt;
    logic              err;
    logic [DATA_W-1:0] data;
  } req_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              lost;
    logic              err;
  } res_t;
endpackage

// File: rtl/shift_pipe_stage_if.sv
// shift_pipe_stage_if: request and result handshake bundle of the shift stage
interface shift_pipe_stage_if;
  import shift_pipe_stage_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [OPR_W-1:0]  in_opr;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] in_shamt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_zero;
  logic              out_lost;
  logic              out_err;
  modport master (output in_valid, in_opr, in_data, in_shamt, out_ready,
                  input in_ready, out_valid, out_data, out_zero, out_lost, out_err);
  modport slave (input in_valid, in_opr, in_data, in_shamt, out_ready,
                 output in_ready, out_valid, out_data, out_zero, out_lost, out_err);
endinterface

// File: rtl/shift_pipe_stage_core.sv
// shift32_core: 5-row zero-fill barrel shifter; right shift reuses the left rows via bit reversal
module shift32_core
  import shift_pipe_stage_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [4:0]        amt,
  input  logic              dir,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] rev_in, rev_out;
  logic [5:0][DATA_W-1:0] row;
  for (genvar b = 0; b < DATA_W; b++) begin : g_rev
    assign rev_in[b]  = data[DATA_W-1-b];
    assign rev_out[b] = row[5][DATA_W-1-b];
  end
  assign row[0] = dir ? data : rev_in;
  for (genvar r = 0; r < 5; r++) begin : g_row
    assign row[r+1] = amt[r] ? {row[r][DATA_W-1-(2**r):0], {(2**r){1'b0}}} : row[r];
  end
  assign result = dir ? row[5] : rev_out;
endmodule

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: two-register valid/ready shift stage (request reg A, result reg B)
module shift_pipe_stage
  import shift_pipe_stage_pkg::*;
(
  input logic CLK,
  input logic RST,
  shift_pipe_stage_if.slave bus
);
  req_t a_q, a_d, new_req;
  res_t b_q, b_d, res;
  logic a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic b_load, in_ready, in_xfer;
  logic [DATA_W-1:0] shifted, lost_mask;
  shift32_core u_core (.data(a_q.data), .amt(a_q.amt), .dir(a_q.dir), .result(shifted));
  always_comb begin
    b_load = a_valid_q && (!b_valid_q || bus.out_ready);
    in_ready = !a_valid_q || b_load;
    in_xfer = bus.in_valid && in_ready;
    new_req.dir = bus.in_opr == OPR_SHIFT_L;
    new_req.sat = |bus.in_shamt[DATA_W-1:5];
    new_req.amt = bus.in_shamt[4:0];
    new_req.err = bus.in_opr != OPR_SHIFT_L && bus.in_opr != OPR_SHIFT_R;
    new_req.data = bus.in_data;
    a_valid_d = in_xfer || (a_valid_q && !b_load);
    a_d = in_xfer ? new_req : a_q;
    // mask marks the bits that leave the word: top amt bits for left, bottom amt bits for right
    lost_mask = a_q.dir ? ~({DATA_W{1'b1}} >> a_q.amt) : ~({DATA_W{1'b1}} << a_q.amt);
    res.data = (a_q.err || a_q.sat) ? '0 : shifted;
    res.zero = ~|res.data;
    res.lost = !a_q.err && (a_q.sat ? |a_q.data : |(a_q.data & lost_mask));
    res.err = a_q.err;
    b_valid_d = b_load || (b_valid_q && !bus.out_ready);
    b_d = b_load ? res : b_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q <= '0;
      a_valid_q <= 1'b0;
      b_q <= '0;
      b_valid_q <= 1'b0;
    end else begin
      a_q <= a_d;
      a_valid_q <= a_valid_d;
      b_q <= b_d;
      b_valid_q <= b_valid_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = b_valid_q;
  assign bus.out_data = b_q.data;
  assign bus.out_zero = b_q.zero;
  assign bus.out_lost = b_q.lost;
  assign bus.out_err = b_q.err;
endmodule
